bp_update_queue: RTL and testbench
==================================

// Module: bp_update_queue
// PURPOSE
// - In-order queue between the frontend and the tournament branch predictor, on the predictor's update side.
// - Frontend pushes each predicted branch: pc, predicted taken/valid, and predictor metadata (gindex/lindex, gbp/lbp valid+taken).
// - Execute pops entries in program order as branches resolve.
// - The block emits the bht_update record (valid, pc, taken, metadata) to the predictor, plus a mispredict flag.
// PARAMETERS
// - VLEN        64  PC width
// - GIDX_BITS   10  global predictor index width
// - LIDX_BITS   10  local predictor index width
// - DEPTH        8  queue entries; power of two, >=2
// - META_W derived = GIDX_BITS+LIDX_BITS+4; packing {gindex,gbp_valid,gbp_taken,lindex,lbp_valid,lbp_taken}, MSB first
// PORTS
// - clk_i            in   1        clock, rising edge
// - rst_ni           in   1        synchronous active-low reset
// - flush_i          in   1        discard all queued entries
// - debug_mode_i     in   1        suppress predictor updates
// - push_valid_i     in   1        frontend offers a predicted branch
// - push_ready_o     out  1        queue can accept (= !full)
// - push_pc_i        in   VLEN     branch PC
// - push_pred_i      in   2        {pred_valid, pred_taken}
// - push_meta_i      in   META_W   predictor metadata
// - resolve_valid_i  in   1        oldest branch resolved this cycle
// - resolve_taken_i  in   1        actual outcome
// - upd_valid_o      out  1        bht_update.valid
// - upd_pc_o         out  VLEN     bht_update.pc
// - upd_taken_o      out  1        bht_update.taken
// - upd_meta_o       out  META_W   bht_update.metadata
// - mispredict_o     out  1        qualified by upd_valid_o
// - count_o          out  $clog2(DEPTH)+1   occupancy
// - err_o            out  1        sticky: resolve arrived while empty
// BEHAVIOUR
// - Reset (rst_ni=0 at clk edge): rd/wr pointers=0, count_o=0, err_o=0; upd_valid_o, upd_taken_o, mispredict_o=0; upd_pc_o, upd_meta_o=0.
// - Push accepted when push_valid_i && push_ready_o; entry written at wr_ptr; wr_ptr wraps DEPTH-1 -> 0.
// - push_ready_o = (count_o != DEPTH); no same-cycle bypass from a pop when full.
// - Resolve while count_o != 0: head entry popped and rd_ptr advanced.
//   - Next cycle (latency 1, registered) upd_valid_o=1 unless debug_mode_i was 1 in the resolve cycle.
//   - upd_pc_o=head pc, upd_taken_o=resolve_taken_i, upd_meta_o=head meta, unmodified.
//   - mispredict_o = !pred_valid ? resolve_taken_i : (pred_taken != resolve_taken_i).
// - Resolve while empty: no pop, no update, err_o set until reset. Push in the same cycle is not bypassed.
// - upd_valid_o is a one-cycle pulse per resolve; data outputs hold their last value otherwise.
// - Push and resolve in the same cycle: both happen and count_o is unchanged. When count=0, the push is stored and the resolve is treated as an error.
// - flush_i: pointers and count cleared next cycle; any same-cycle push or resolve is ignored. An update already registered from the previous cycle still emits.
// - count_o = number of valid entries, range 0..DEPTH; pointer wrap handled with an extra MSB.
// CONFIGURATION
// - BP_UPDATE_STATS_EN defined: adds outputs stat_upd_o[31:0] and stat_mispred_o[31:0].
//   - Both saturate at 2^32-1, reset to 0, and are not cleared by flush.
//   - stat_upd_o increments on each upd_valid_o pulse; stat_mispred_o on each pulse with mispredict_o=1.
// - Macro undefined: those ports and counters do not exist; all other behaviour is identical.
// TESTING
// - Reset, push pc=0x1000 pred={1,1}, resolve taken=1 -> next cycle upd_valid_o=1, upd_pc_o=0x1000, mispredict_o=0.
// - Push pred={0,0} then resolve taken=1 -> mispredict_o=1; metadata 0x2AB_F3 returned bit-exact.
// - DEPTH=8: push 8 -> push_ready_o=0, count_o=8.
//   - 9th push held off; push+resolve together while full -> accepted next cycle.
//   - 20 push/pop pairs wrap the pointers; FIFO order preserved.
// - Resolve on an empty queue -> no upd_valid_o, err_o=1 and sticky until rst_ni=0.
// - Push 5, flush_i with a simultaneous resolve -> count_o=0, no update from that resolve; next push/resolve works normally.
// - debug_mode_i=1 during resolve -> entry popped, upd_valid_o stays 0. With BP_UPDATE_STATS_EN, 3 updates incl. 2 mispredicts -> stat_upd_o=3, stat_mispred_o=2.

Source files
------------

// File: rtl/bp_update_queue.sv
// In-order queue feeding branch resolutions back to the tournament predictor.
// Optional BP_UPDATE_STATS_EN adds saturating update/mispredict counters.
module bp_update_queue #(
    parameter  int VLEN      = 64,
    parameter  int GIDX_BITS = 10,
    parameter  int LIDX_BITS = 10,
    parameter  int DEPTH     = 8,
    localparam int META_W    = GIDX_BITS + LIDX_BITS + 4,
    localparam int AW        = $clog2(DEPTH)
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              flush_i,
    input  logic              debug_mode_i,
    input  logic              push_valid_i,
    output logic              push_ready_o,
    input  logic [VLEN-1:0]   push_pc_i,
    input  logic [1:0]        push_pred_i,
    input  logic [META_W-1:0] push_meta_i,
    input  logic              resolve_valid_i,
    input  logic              resolve_taken_i,
    output logic              upd_valid_o,
    output logic [VLEN-1:0]   upd_pc_o,
    output logic              upd_taken_o,
    output logic [META_W-1:0] upd_meta_o,
    output logic              mispredict_o,
    output logic [AW:0]       count_o,
    output logic              err_o
`ifdef BP_UPDATE_STATS_EN
    ,
    output logic [31:0]       stat_upd_o,
    output logic [31:0]       stat_mispred_o
`endif
);

    localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

    logic [VLEN-1:0]   pc_mem   [DEPTH];
    logic [1:0]        pred_mem [DEPTH];
    logic [META_W-1:0] meta_mem [DEPTH];

    // Extra MSB on each pointer distinguishes full from empty.
    logic [AW:0]   wr_ptr, rd_ptr;
    logic [AW-1:0] wr_idx, rd_idx;
    logic          empty, do_push, do_pop, bad_resolve, emit;
    logic [1:0]    head_pred;
    logic          mis;

    assign wr_idx       = wr_ptr[AW-1:0];
    assign rd_idx       = rd_ptr[AW-1:0];
    assign count_o      = wr_ptr - rd_ptr;
    assign empty        = (count_o == '0);
    assign push_ready_o = (count_o != FULL_CNT);

    assign do_push     = push_valid_i && push_ready_o && !flush_i;
    assign do_pop      = resolve_valid_i && !empty && !flush_i;
    assign bad_resolve = resolve_valid_i && empty && !flush_i;
    assign emit        = do_pop && !debug_mode_i;

    assign head_pred = pred_mem[rd_idx];
    assign mis = !head_pred[1] ? resolve_taken_i
                               : (head_pred[0] != resolve_taken_i);

    always_ff @(posedge clk_i) begin
        if (do_push) begin
            pc_mem[wr_idx]   <= push_pc_i;
            pred_mem[wr_idx] <= push_pred_i;
            meta_mem[wr_idx] <= push_meta_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            err_o  <= 1'b0;
        end else if (flush_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop) rd_ptr <= rd_ptr + 1'b1;
            if (bad_resolve) err_o <= 1'b1;
        end
    end

    // Data outputs hold their last value between update pulses.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            upd_valid_o  <= 1'b0;
            upd_pc_o     <= '0;
            upd_taken_o  <= 1'b0;
            upd_meta_o   <= '0;
            mispredict_o <= 1'b0;
        end else begin
            upd_valid_o <= emit;
            if (emit) begin
                upd_pc_o     <= pc_mem[rd_idx];
                upd_taken_o  <= resolve_taken_i;
                upd_meta_o   <= meta_mem[rd_idx];
                mispredict_o <= mis;
            end
        end
    end

`ifdef BP_UPDATE_STATS_EN
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            stat_upd_o     <= '0;
            stat_mispred_o <= '0;
        end else if (upd_valid_o) begin
            if (stat_upd_o != '1) stat_upd_o <= stat_upd_o + 1'b1;
            if (mispredict_o && stat_mispred_o != '1)
                stat_mispred_o <= stat_mispred_o + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_bp_update_queue.sv
// Directed bench for bp_update_queue with a FIFO model and update scoreboard.
// Stats checks are compiled in when BP_UPDATE_STATS_EN is defined.
module tb_bp_update_queue;

    localparam int DEPTH  = 8;
    localparam int META_W = 24;

    typedef struct packed {
        logic [63:0]       pc;
        logic [1:0]        pred;
        logic [META_W-1:0] meta;
    } ent_t;

    typedef struct packed {
        logic [63:0]       pc;
        logic              taken;
        logic [META_W-1:0] meta;
        logic              mis;
    } upd_t;

    logic              clk = 1'b0;
    logic              rst_ni = 1'b0;
    logic              flush_i = 1'b0;
    logic              debug_mode_i = 1'b0;
    logic              push_valid_i = 1'b0;
    logic              push_ready_o;
    logic [63:0]       push_pc_i = '0;
    logic [1:0]        push_pred_i = '0;
    logic [META_W-1:0] push_meta_i = '0;
    logic              resolve_valid_i = 1'b0;
    logic              resolve_taken_i = 1'b0;
    logic              upd_valid_o;
    logic [63:0]       upd_pc_o;
    logic              upd_taken_o;
    logic [META_W-1:0] upd_meta_o;
    logic              mispredict_o;
    logic [3:0]        count_o;
    logic              err_o;
`ifdef BP_UPDATE_STATS_EN
    logic [31:0]       stat_upd_o;
    logic [31:0]       stat_mispred_o;
    int unsigned       st_upd;
    int unsigned       st_mis;
`endif

    bp_update_queue dut (
        .clk_i          (clk),
        .rst_ni         (rst_ni),
        .flush_i        (flush_i),
        .debug_mode_i   (debug_mode_i),
        .push_valid_i   (push_valid_i),
        .push_ready_o   (push_ready_o),
        .push_pc_i      (push_pc_i),
        .push_pred_i    (push_pred_i),
        .push_meta_i    (push_meta_i),
        .resolve_valid_i(resolve_valid_i),
        .resolve_taken_i(resolve_taken_i),
        .upd_valid_o    (upd_valid_o),
        .upd_pc_o       (upd_pc_o),
        .upd_taken_o    (upd_taken_o),
        .upd_meta_o     (upd_meta_o),
        .mispredict_o   (mispredict_o),
        .count_o        (count_o),
        .err_o          (err_o)
`ifdef BP_UPDATE_STATS_EN
        ,
        .stat_upd_o     (stat_upd_o),
        .stat_mispred_o (stat_mispred_o)
`endif
    );

    always #5 clk = ~clk;

    int   total;
    int   passed;
    ent_t mq[$];
    upd_t sb[$];
    logic exp_err;
    logic [63:0] pc_seq;

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_ni = 1'b0;
        tick();
        rst_ni = 1'b1;
        mq.delete();
        sb.delete();
        exp_err = 1'b0;
        chk("rst_count", 64'(count_o), 0);
        chk("rst_err", 64'(err_o), 0);
        chk("rst_upd_valid", 64'(upd_valid_o), 0);
        chk("rst_upd_pc", upd_pc_o, 0);
        chk("rst_upd_taken", 64'(upd_taken_o), 0);
        chk("rst_upd_meta", 64'(upd_meta_o), 0);
        chk("rst_mispredict", 64'(mispredict_o), 0);
        chk("rst_push_ready", 64'(push_ready_o), 1);
`ifdef BP_UPDATE_STATS_EN
        st_upd = 0;
        st_mis = 0;
        chk("rst_stat_upd", 64'(stat_upd_o), 0);
        chk("rst_stat_mis", 64'(stat_mispred_o), 0);
`endif
    endtask

    // One clock: drive, advance the model, then check registered outputs.
    task automatic cyc(input logic pv, input logic [63:0] pc,
                       input logic [1:0] pr, input logic [META_W-1:0] mt,
                       input logic rv, input logic tk,
                       input logic fl, input logic dbg);
        int   n;
        ent_t e;
        upd_t u;
        logic pulse;
        n = mq.size();
        chk("push_ready", 64'(push_ready_o), 64'(n != DEPTH));
        push_valid_i    = pv;
        push_pc_i       = pc;
        push_pred_i     = pr;
        push_meta_i     = mt;
        resolve_valid_i = rv;
        resolve_taken_i = tk;
        flush_i         = fl;
        debug_mode_i    = dbg;
        if (!fl) begin
            if (rv && n == 0) exp_err = 1'b1;
            if (rv && n != 0) begin
                e = mq.pop_front();
                u.pc    = e.pc;
                u.taken = tk;
                u.meta  = e.meta;
                u.mis   = !e.pred[1] ? tk : (e.pred[0] != tk);
                if (!dbg) sb.push_back(u);
            end
            if (pv && n != DEPTH) mq.push_back('{pc, pr, mt});
        end else begin
            mq.delete();
        end
        tick();
        push_valid_i    = 1'b0;
        resolve_valid_i = 1'b0;
        flush_i         = 1'b0;
        debug_mode_i    = 1'b0;
        pulse = 1'b0;
        if (sb.size() != 0) begin
            u = sb.pop_front();
            pulse = 1'b1;
            chk("upd_valid", 64'(upd_valid_o), 1);
            chk("upd_pc", upd_pc_o, u.pc);
            chk("upd_taken", 64'(upd_taken_o), 64'(u.taken));
            chk("upd_meta", 64'(upd_meta_o), 64'(u.meta));
            chk("mispredict", 64'(mispredict_o), 64'(u.mis));
        end else begin
            chk("upd_idle", 64'(upd_valid_o), 0);
        end
        chk("count", 64'(count_o), 64'(mq.size()));
        chk("err", 64'(err_o), 64'(exp_err));
`ifdef BP_UPDATE_STATS_EN
        chk("stat_upd", 64'(stat_upd_o), 64'(st_upd));
        chk("stat_mis", 64'(stat_mispred_o), 64'(st_mis));
        if (pulse) begin
            st_upd++;
            if (u.mis) st_mis++;
        end
`else
        if (pulse) pc_seq = pc_seq;
`endif
    endtask

    task automatic push(input logic [1:0] pr, input logic [META_W-1:0] mt);
        pc_seq = pc_seq + 64'h4;
        cyc(1'b1, pc_seq, pr, mt, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic resolve(input logic tk);
        cyc(1'b0, '0, '0, '0, 1'b1, tk, 1'b0, 1'b0);
    endtask

    task automatic idle();
        cyc(1'b0, '0, '0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        total   = 0;
        passed  = 0;
        exp_err = 1'b0;
        pc_seq  = 64'h2000;
        do_reset();

        cyc(1'b1, 64'h1000, 2'b11, 24'h0ABCDE, 1'b0, 1'b0, 1'b0, 1'b0);
        resolve(1'b1);
        chk("basic_pc", upd_pc_o, 64'h1000);
        chk("basic_mis", 64'(mispredict_o), 0);
        idle();

        cyc(1'b1, 64'h1100, 2'b00, 24'h02ABF3, 1'b0, 1'b0, 1'b0, 1'b0);
        resolve(1'b1);
        chk("mis_flag", 64'(mispredict_o), 1);
        chk("meta_exact", 64'(upd_meta_o), 64'h02ABF3);

        for (int i = 0; i < DEPTH; i++)
            push(2'($urandom_range(3)), 24'($urandom));
        chk("full_count", 64'(count_o), 8);
        chk("full_ready", 64'(push_ready_o), 0);
        push(2'b11, 24'h111111);
        cyc(1'b1, 64'hDEAD, 2'b10, 24'h222222, 1'b1, 1'b0, 1'b0, 1'b0);
        push(2'b10, 24'h333333);
        chk("refill_count", 64'(count_o), 8);
        for (int i = 0; i < DEPTH; i++) resolve(1'($urandom_range(1)));

        push(2'b11, 24'($urandom));
        for (int i = 0; i < 20; i++) begin
            pc_seq = pc_seq + 64'h4;
            cyc(1'b1, pc_seq, 2'($urandom_range(3)), 24'($urandom),
                1'b1, 1'($urandom_range(1)), 1'b0, 1'b0);
        end
        resolve(1'b0);
        chk("wrap_empty", 64'(count_o), 0);

        resolve(1'b1);
        chk("err_set", 64'(err_o), 1);
        idle();
        cyc(1'b1, 64'h5000, 2'b11, 24'h00F00F, 1'b1, 1'b1, 1'b0, 1'b0);
        resolve(1'b0);
        chk("err_sticky", 64'(err_o), 1);
        do_reset();

        for (int i = 0; i < 5; i++) push(2'b10, 24'($urandom));
        cyc(1'b0, '0, '0, '0, 1'b1, 1'b1, 1'b1, 1'b0);
        chk("flush_count", 64'(count_o), 0);
        push(2'b01, 24'h0C0FFE);
        resolve(1'b1);

        push(2'b11, 24'h000001);
        push(2'b11, 24'h000002);
        cyc(1'b0, '0, '0, '0, 1'b1, 1'b0, 1'b0, 1'b1);
        chk("dbg_count", 64'(count_o), 1);
        resolve(1'b1);
        idle();

        do_reset();
        push(2'b11, 24'h0000A1);
        push(2'b10, 24'h0000A2);
        push(2'b00, 24'h0000A3);
        resolve(1'b0);
        resolve(1'b0);
        resolve(1'b1);
        idle();
        idle();
`ifdef BP_UPDATE_STATS_EN
        chk("stat_upd_3", 64'(stat_upd_o), 3);
        chk("stat_mis_2", 64'(stat_mispred_o), 2);
`endif

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
